// File: rtl/sg_spec_monitor.sv
// Monitors a circuit against a state graph held in a loadable transition table.
// An unmatched single-signal change or a multi-signal change is a violation.
module sg_spec_monitor #(
  parameter int NSIG = 8,
  parameter int SW = 4,
  parameter int NTRANS = 32,
  parameter int CW = 8,
  parameter logic [NSIG-1:0] OUT_MASK = '0,
  localparam int AW = $clog2(NTRANS),
  localparam int SIW = $clog2(NSIG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [SW-1:0]   i_init_state,
  input  logic            i_en,
  input  logic            i_clear,
  input  logic [NSIG-1:0] i_sig,
  input  logic            i_tbl_we,
  input  logic [AW-1:0]   i_tbl_addr,
  input  logic            i_tbl_valid,
  input  logic            i_tbl_dir,
  input  logic [SIW-1:0]  i_tbl_sig,
  input  logic [SW-1:0]   i_tbl_from,
  input  logic [SW-1:0]   i_tbl_to,
  output logic            o_armed,
  output logic [SW-1:0]   o_state,
  output logic            o_viol_in,
  output logic            o_viol_out,
  output logic            o_viol_multi,
  output logic            o_nondet,
  output logic            o_err_valid,
  output logic [1:0]      o_err_kind,
  output logic [SIW-1:0]  o_err_sig,
  output logic            o_err_dir,
  output logic [SW-1:0]   o_err_state,
  output logic [CW-1:0]   o_viol_count
);

  logic            r_armed;
  logic [SW-1:0]   r_state;
  logic [NSIG-1:0] r_prev;
  logic            r_viol_in, r_viol_out, r_viol_multi, r_nondet;
  logic            r_err_valid, r_err_dir;
  logic [1:0]      r_err_kind;
  logic [SIW-1:0]  r_err_sig;
  logic [SW-1:0]   r_err_state;
  logic [CW-1:0]   r_count;

  logic            r_tbl_valid [NTRANS];
  logic            r_tbl_dir   [NTRANS];
  logic [SIW-1:0]  r_tbl_sig   [NTRANS];
  logic [SW-1:0]   r_tbl_from  [NTRANS];
  logic [SW-1:0]   r_tbl_to    [NTRANS];

  logic [NSIG-1:0]   w_delta;
  logic [NTRANS-1:0] w_match;
  logic [SIW-1:0]    w_k;
  logic [AW-1:0]     w_hit_idx;
  logic              w_tbl_wr, w_check, w_changed, w_multi, w_single, w_dir;
  logic              w_hit, w_nd, w_miss, w_vin, w_vout, w_vmulti, w_viol;
  logic [1:0]        w_kind;

  // Table is only writable while the monitor is idle, so a running check never sees it change.
  assign w_tbl_wr = i_tbl_we & ~r_armed & ~i_start;

  genvar gi;
  generate
    for (gi = 0; gi < NTRANS; gi++) begin : g_tbl
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tbl_valid[gi] <= 1'b0;
          r_tbl_dir[gi]   <= 1'b0;
          r_tbl_sig[gi]   <= '0;
          r_tbl_from[gi]  <= '0;
          r_tbl_to[gi]    <= '0;
        end else if (w_tbl_wr && i_tbl_addr == AW'(gi)) begin
          r_tbl_valid[gi] <= i_tbl_valid;
          r_tbl_dir[gi]   <= i_tbl_dir;
          r_tbl_sig[gi]   <= i_tbl_sig;
          r_tbl_from[gi]  <= i_tbl_from;
          r_tbl_to[gi]    <= i_tbl_to;
        end
      end
      assign w_match[gi] = r_tbl_valid[gi] & (r_tbl_from[gi] == r_state) &
                           (r_tbl_sig[gi] == w_k) & (r_tbl_dir[gi] == w_dir);
    end
  endgenerate

  assign w_delta   = i_sig ^ r_prev;
  assign w_check   = r_armed & i_en & ~i_start;
  assign w_changed = |w_delta;
  assign w_multi   = w_changed & (|(w_delta & (w_delta - NSIG'(1))));
  assign w_single  = w_changed & ~w_multi;
  assign w_dir     = i_sig[w_k];
  assign w_hit     = |w_match;
  assign w_nd      = |(w_match & (w_match - NTRANS'(1)));

  // Lowest changed signal and lowest-index matching entry.
  always_comb begin
    w_k = '0;
    for (int i = NSIG - 1; i >= 0; i--)
      if (w_delta[i]) w_k = SIW'(i);
    w_hit_idx = '0;
    for (int i = NTRANS - 1; i >= 0; i--)
      if (w_match[i]) w_hit_idx = AW'(i);
  end

  assign w_miss   = w_check & w_single & ~w_hit;
  assign w_vin    = w_miss & ~OUT_MASK[w_k];
  assign w_vout   = w_miss & OUT_MASK[w_k];
  assign w_vmulti = w_check & w_multi;
  assign w_viol   = w_miss | w_vmulti;
  assign w_kind   = w_vmulti ? 2'd2 : (OUT_MASK[w_k] ? 2'd1 : 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed      <= 1'b0;
      r_state      <= '0;
      r_prev       <= '0;
      r_viol_in    <= 1'b0;
      r_viol_out   <= 1'b0;
      r_viol_multi <= 1'b0;
      r_nondet     <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_kind   <= '0;
      r_err_sig    <= '0;
      r_err_dir    <= 1'b0;
      r_err_state  <= '0;
      r_count      <= '0;
    end else begin
      r_viol_in    <= w_vin;
      r_viol_out   <= w_vout;
      r_viol_multi <= w_vmulti;
      if (i_start) begin
        r_armed <= 1'b1;
        r_state <= i_init_state;
        r_prev  <= i_sig;
      end else if (w_check) begin
        r_prev <= i_sig;
        if (w_single && w_hit) r_state <= r_tbl_to[w_hit_idx];
      end
      if (i_clear) begin
        r_err_valid <= 1'b0;
        r_err_kind  <= '0;
        r_err_sig   <= '0;
        r_err_dir   <= 1'b0;
        r_err_state <= '0;
        r_nondet    <= 1'b0;
      end
      if (w_check && w_single && w_nd) r_nondet <= 1'b1;
      // A violation coinciding with clear is recorded as the first one after clear.
      if (w_viol) begin
        if (i_clear) r_count <= CW'(1);
        else if (r_count != {CW{1'b1}}) r_count <= r_count + 1'b1;
        if (!r_err_valid || i_clear) begin
          r_err_valid <= 1'b1;
          r_err_kind  <= w_kind;
          r_err_sig   <= w_k;
          r_err_dir   <= w_dir;
          r_err_state <= r_state;
        end
      end else if (i_clear) begin
        r_count <= '0;
      end
    end
  end

  assign o_armed      = r_armed;
  assign o_state      = r_state;
  assign o_viol_in    = r_viol_in;
  assign o_viol_out   = r_viol_out;
  assign o_viol_multi = r_viol_multi;
  assign o_nondet     = r_nondet;
  assign o_err_valid  = r_err_valid;
  assign o_err_kind   = r_err_kind;
  assign o_err_sig    = r_err_sig;
  assign o_err_dir    = r_err_dir;
  assign o_err_state  = r_err_state;
  assign o_viol_count = r_count;

endmodule

// File: tb/tb_sg_spec_monitor.sv
// Bench for sg_spec_monitor: directed handshake scenarios plus randomized traffic
// checked against a transaction-level model of the state-graph rules.
module tb_sg_spec_monitor;
  localparam int NSIG = 2;
  localparam int SW = 4;
  localparam int NTRANS = 32;
  localparam int CW = 8;
  localparam int AW = 5;
  localparam int SIW = 1;
  localparam logic [NSIG-1:0] OUT_MASK = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 0, i_en = 0, i_clear = 0, i_tbl_we = 0, i_tbl_valid = 0, i_tbl_dir = 0;
  logic [SW-1:0] i_init_state = '0, i_tbl_from = '0, i_tbl_to = '0;
  logic [NSIG-1:0] i_sig = '0;
  logic [AW-1:0] i_tbl_addr = '0;
  logic [SIW-1:0] i_tbl_sig = '0;
  logic o_armed, o_viol_in, o_viol_out, o_viol_multi, o_nondet, o_err_valid, o_err_dir;
  logic [SW-1:0] o_state, o_err_state;
  logic [1:0] o_err_kind;
  logic [SIW-1:0] o_err_sig;
  logic [CW-1:0] o_viol_count;

  always #5 clk = ~clk;

  sg_spec_monitor #(.NSIG(NSIG), .SW(SW), .NTRANS(NTRANS), .CW(CW), .OUT_MASK(OUT_MASK)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_init_state(i_init_state), .i_en(i_en),
    .i_clear(i_clear), .i_sig(i_sig), .i_tbl_we(i_tbl_we), .i_tbl_addr(i_tbl_addr),
    .i_tbl_valid(i_tbl_valid), .i_tbl_dir(i_tbl_dir), .i_tbl_sig(i_tbl_sig),
    .i_tbl_from(i_tbl_from), .i_tbl_to(i_tbl_to), .o_armed(o_armed), .o_state(o_state),
    .o_viol_in(o_viol_in), .o_viol_out(o_viol_out), .o_viol_multi(o_viol_multi),
    .o_nondet(o_nondet), .o_err_valid(o_err_valid), .o_err_kind(o_err_kind),
    .o_err_sig(o_err_sig), .o_err_dir(o_err_dir), .o_err_state(o_err_state),
    .o_viol_count(o_viol_count));

  int checks = 0;
  int errors = 0;

  // Reference model: table as plain arrays, state graph walked per transaction.
  bit m_v [NTRANS];
  bit m_d [NTRANS];
  int m_s [NTRANS];
  int m_f [NTRANS];
  int m_t [NTRANS];
  bit m_armed, m_errv, m_edir, m_nondet, m_vin, m_vout, m_vmulti;
  int m_state, m_count, m_kind, m_esig, m_estate;
  logic [NSIG-1:0] m_prev;

  task automatic model_reset();
    for (int e = 0; e < NTRANS; e++) m_v[e] = 0;
    m_armed = 0; m_state = 0; m_prev = '0; m_count = 0; m_errv = 0; m_kind = 0;
    m_esig = 0; m_edir = 0; m_estate = 0; m_nondet = 0; m_vin = 0; m_vout = 0; m_vmulti = 0;
  endtask

  task automatic record(input int kind, input int k);
    m_count = (m_count < 255) ? m_count + 1 : 255;
    if (!m_errv) begin
      m_errv = 1; m_kind = kind; m_esig = k; m_edir = i_sig[k]; m_estate = m_state;
    end
  endtask

  task automatic model_edge();
    logic [NSIG-1:0] delta;
    int hits, first, k;
    m_vin = 0; m_vout = 0; m_vmulti = 0;
    if (i_tbl_we && !m_armed && !i_start) begin
      m_v[i_tbl_addr] = i_tbl_valid; m_d[i_tbl_addr] = i_tbl_dir;
      m_s[i_tbl_addr] = int'(i_tbl_sig); m_f[i_tbl_addr] = int'(i_tbl_from);
      m_t[i_tbl_addr] = int'(i_tbl_to);
    end
    if (i_clear) begin
      m_errv = 0; m_kind = 0; m_esig = 0; m_edir = 0; m_estate = 0; m_count = 0; m_nondet = 0;
    end
    if (i_start) begin
      m_armed = 1; m_state = int'(i_init_state); m_prev = i_sig;
    end else if (m_armed && i_en) begin
      delta = i_sig ^ m_prev;
      m_prev = i_sig;
      k = 0;
      for (int b = NSIG - 1; b >= 0; b--) if (delta[b]) k = b;
      if ($countones(delta) == 1) begin
        hits = 0; first = -1;
        for (int e = 0; e < NTRANS; e++)
          if (m_v[e] && m_f[e] == m_state && m_s[e] == k && m_d[e] == i_sig[k]) begin
            hits++;
            if (first < 0) first = e;
          end
        if (hits > 0) begin
          m_state = m_t[first];
          if (hits > 1) m_nondet = 1;
        end else begin
          if (OUT_MASK[k]) m_vout = 1; else m_vin = 1;
          record(OUT_MASK[k] ? 1 : 0, k);
        end
      end else if ($countones(delta) > 1) begin
        m_vmulti = 1;
        record(2, k);
      end
    end
  endtask

  function automatic logic [31:0] dut_snap();
    return {6'd0, o_armed, o_state, o_viol_in, o_viol_out, o_viol_multi, o_nondet,
            o_err_valid, o_err_kind, o_err_sig, o_err_dir, o_err_state, o_viol_count};
  endfunction

  function automatic logic [31:0] model_snap();
    return {6'd0, m_armed, 4'(m_state), m_vin, m_vout, m_vmulti, m_nondet,
            m_errv, 2'(m_kind), 1'(m_esig), m_edir, 4'(m_estate), 8'(m_count)};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    $display("t=%0t sig=%b en=%0b st=%0b clr=%0b -> armed=%0b state=%0d vin=%0b vout=%0b vmul=%0b cnt=%0d",
             $time, i_sig, i_en, i_start, i_clear, o_armed, o_state, o_viol_in, o_viol_out,
             o_viol_multi, o_viol_count);
    i_start = 0; i_clear = 0; i_tbl_we = 0;
  endtask

  task automatic load(input int addr, input int v, input int d, input int s, input int f, input int t);
    i_tbl_addr = AW'(addr); i_tbl_valid = v[0]; i_tbl_dir = d[0];
    i_tbl_sig = SIW'(s); i_tbl_from = SW'(f); i_tbl_to = SW'(t); i_tbl_we = 1;
    tick();
  endtask

  task automatic load_handshake();
    load(0, 1, 1, 0, 0, 1);
    load(1, 1, 1, 1, 1, 2);
    load(2, 1, 0, 0, 2, 3);
    load(3, 1, 0, 1, 3, 0);
  endtask

  task automatic arm(input int init, input logic [NSIG-1:0] s);
    i_init_state = SW'(init); i_sig = s; i_start = 1;
    tick();
  endtask

  task automatic drive(input logic [NSIG-1:0] s);
    i_sig = s;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1;
    model_reset();
    #3;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (dut_snap() !== 32'd0) begin
      $display("FAIL reset_outputs actual=%h required=%h", dut_snap(), 32'd0); errors++;
    end
    @(negedge clk);
    reset = 0;
    i_en = 1;
    tick();
    checks++;
    if (dut_snap() !== model_snap()) begin
      $display("FAIL reset_idle actual=%h required=%h", dut_snap(), model_snap()); errors++;
    end
  endtask

  task automatic test_handshake();
    logic [NSIG-1:0] seq [4];
    int exp_st [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    exp_st = '{1, 2, 3, 0};
    load_handshake();
    arm(0, 2'b00);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) begin
        drive(seq[i]);
        checks++;
        if (o_state !== SW'(exp_st[i]) || o_viol_in || o_viol_out || o_viol_multi) begin
          $display("FAIL handshake_step pass=%0d step=%0d state=%0d required=%0d pulses=%b%b%b",
                   p, i, o_state, exp_st[i], o_viol_in, o_viol_out, o_viol_multi); errors++;
        end
      end
    checks++;
    if (o_viol_count !== 8'd0 || o_err_valid !== 1'b0) begin
      $display("FAIL handshake_count actual=%0d required=0", o_viol_count); errors++;
    end
  endtask

  task automatic test_out_viol();
    drive(2'b10);
    checks++;
    if ({o_viol_out, o_err_kind, o_err_sig, o_err_dir, o_err_state, o_state, o_viol_count} !==
        {1'b1, 2'd1, 1'b1, 1'b1, 4'd0, 4'd0, 8'd1}) begin
      $display("FAIL out_viol vout=%0b kind=%0d sig=%0d dir=%0b estate=%0d state=%0d cnt=%0d required 1 1 1 1 0 0 1",
               o_viol_out, o_err_kind, o_err_sig, o_err_dir, o_err_state, o_state, o_viol_count);
      errors++;
    end
    drive(2'b10);
    checks++;
    if (o_viol_out !== 1'b0) begin
      $display("FAIL out_viol_pulse_width actual=%0b required=0", o_viol_out); errors++;
    end
  endtask

  task automatic test_in_multi();
    i_clear = 1;
    arm(0, 2'b00);
    drive(2'b01);
    checks++;
    if (o_state !== 4'd1 || o_err_valid !== 1'b0) begin
      $display("FAIL in_multi_setup state=%0d errv=%0b required 1 0", o_state, o_err_valid); errors++;
    end
    drive(2'b00);
    checks++;
    if (o_viol_in !== 1'b1 || o_err_kind !== 2'd0 || o_err_state !== 4'd1 || o_err_dir !== 1'b0) begin
      $display("FAIL in_viol vin=%0b kind=%0d estate=%0d dir=%0b required 1 0 1 0",
               o_viol_in, o_err_kind, o_err_state, o_err_dir); errors++;
    end
    drive(2'b11);
    checks++;
    if (o_viol_multi !== 1'b1 || o_viol_count !== 8'd2 || o_err_kind !== 2'd0 || o_state !== 4'd1) begin
      $display("FAIL multi_viol vmul=%0b cnt=%0d kind=%0d state=%0d required 1 2 0 1",
               o_viol_multi, o_viol_count, o_err_kind, o_state); errors++;
    end
  endtask

  task automatic test_saturate();
    i_clear = 1;
    for (int i = 0; i < 300; i++) begin
      drive(~i_sig);
      checks++;
      if (dut_snap() !== model_snap()) begin
        $display("FAIL saturate_step i=%0d actual=%h required=%h", i, dut_snap(), model_snap()); errors++;
      end
    end
    checks++;
    if (o_viol_count !== 8'd255) begin
      $display("FAIL saturate_count actual=%0d required=255", o_viol_count); errors++;
    end
    i_clear = 1;
    drive(~i_sig);
    checks++;
    if (o_viol_count !== 8'd1 || o_err_valid !== 1'b1 || o_err_kind !== 2'd2) begin
      $display("FAIL clear_with_viol cnt=%0d errv=%0b kind=%0d required 1 1 2",
               o_viol_count, o_err_valid, o_err_kind); errors++;
    end
  endtask

  task automatic test_nondet();
    apply_reset();
    load(0, 1, 1, 0, 0, 1);
    load(1, 1, 1, 0, 0, 2);
    arm(0, 2'b00);
    drive(2'b01);
    checks++;
    if (o_state !== 4'd1 || o_nondet !== 1'b1) begin
      $display("FAIL nondet state=%0d nondet=%0b required 1 1", o_state, o_nondet); errors++;
    end
    i_tbl_addr = '0; i_tbl_valid = 1; i_tbl_dir = 1; i_tbl_sig = '0;
    i_tbl_from = '0; i_tbl_to = 4'd3; i_tbl_we = 1;
    drive(2'b01);
    arm(0, 2'b00);
    drive(2'b01);
    checks++;
    if (o_state !== 4'd1) begin
      $display("FAIL armed_write_ignored state=%0d required=1", o_state); errors++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_handshake();
    arm(0, 2'b00);
    drive(2'b01);
    drive(2'b11);
    checks++;
    if (o_state !== 4'd2) begin
      $display("FAIL reset_mid_setup state=%0d required=2", o_state); errors++;
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (dut_snap() !== 32'd0) begin
      $display("FAIL reset_mid_outputs actual=%h required=0", dut_snap()); errors++;
    end
    @(negedge clk);
    reset = 0;
    arm(0, 2'b00);
    drive(2'b01);
    checks++;
    if (o_state !== 4'd0 || o_viol_in !== 1'b1) begin
      $display("FAIL reset_mid_table_cleared state=%0d vin=%0b required 0 1", o_state, o_viol_in); errors++;
    end
    apply_reset();
    load_handshake();
    arm(0, 2'b00);
    drive(2'b01);
    checks++;
    if (o_state !== 4'd1) begin
      $display("FAIL reset_mid_reload state=%0d required=1", o_state); errors++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int e = 0; e < 16; e++)
      load(e, ($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 4, $urandom % 4);
    arm($urandom % 4, NSIG'($urandom));
    for (int c = 0; c < 500; c++) begin
      i_sig = NSIG'($urandom);
      i_en = ($urandom % 4) != 0;
      i_clear = ($urandom % 16) == 0;
      i_start = ($urandom % 32) == 0;
      i_init_state = SW'($urandom % 4);
      i_tbl_we = ($urandom % 8) == 0;
      i_tbl_addr = AW'($urandom); i_tbl_valid = 1; i_tbl_dir = 1'($urandom);
      i_tbl_sig = SIW'($urandom); i_tbl_from = SW'($urandom % 4); i_tbl_to = SW'($urandom % 4);
      tick();
      checks++;
      if (dut_snap() !== model_snap()) begin
        $display("FAIL random_cycle c=%0d actual=%h required=%h", c, dut_snap(), model_snap()); errors++;
      end
    end
    i_en = 1;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_out_viol();
    test_in_multi();
    test_saturate();
    test_nondet();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
